ps2_key_decoder: RTL and testbench

- Downstream consumer of the PS/2 frame receiver. Takes each received 8-bit byte (data_in/data_valid) and runs a Set-2 prefix state machine that merges 0xE0 (extended) and 0xF0 (break) prefixes with the following code byte into one key event.
- Buffers key events in a small first-word-fall-through FIFO with a valid/ready handshake toward the keyboard/application logic.

---
 rtl/ps2_key_decoder.sv | 116 +++++++++++
 tb/tb_ps2_key_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: merges Set-2 E0/F0 prefixes with the next code byte into key events held in a FWFT FIFO.
// Optional macro KEY_TIMEOUT_EN: abandon a partial prefix sequence after TIMEOUT_CYCLES idle clocks.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       fifo_full,
    output logic       overflow,
    input  logic       clr_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_n;
    logic          dv_q, strobe, is_pre, is_ctrl, timeout;
    logic          push, ev_ext, ev_rel, pop, drop;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    assign strobe  = data_valid && !dv_q;
    assign is_pre  = data_in == 8'hE0 || data_in == 8'hF0;
    assign is_ctrl = data_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

`ifdef KEY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt;
    assign timeout = state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt <= '0;
        else      tmo_cnt <= (state_n == IDLE || strobe) ? '0 : tmo_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dv_q  <= 1'b0;
        end else begin
            state <= state_n;
            dv_q  <= data_valid;
        end
    end

    // A strobe coinciding with a timeout is still decoded in the current state.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        ev_ext  = 1'b0;
        ev_rel  = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    state_n = data_in == 8'hE0 ? EXT : data_in == 8'hF0 ? BRK : IDLE;
                    push    = !is_pre && !is_ctrl;
                end
                EXT: begin
                    state_n = data_in == 8'hF0 ? EXT_BRK : data_in == 8'hE0 ? EXT : IDLE;
                    push    = !is_pre;
                    ev_ext  = 1'b1;
                end
                BRK: begin
                    state_n = IDLE;
                    push    = !is_pre;
                    ev_rel  = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    push    = !is_pre;
                    ev_ext  = 1'b1;
                    ev_rel  = 1'b1;
                end
            endcase
        end else if (timeout) begin
            state_n = IDLE;
        end
    end

    assign pop  = key_valid && key_ready;
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && !drop) begin
                mem[wr_ptr] <= {ev_rel, ev_ext, data_in};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(push && !drop) - CW'(pop);
            overflow <= drop || (overflow && !clr_overflow);
        end
    end

    assign {key_release, key_extended, key_code} = mem[rd_ptr];
    assign key_valid = count != '0;
    assign fifo_full = count == CW'(FIFO_DEPTH);
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed stimulus with a scoreboard queue checked by a separate monitor.
module tb_ps2_key_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic [7:0] key_code;
    logic       key_extended, key_release, key_valid, fifo_full, overflow;
    logic       key_ready = 1'b0;
    logic       clr_overflow = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .key_code(key_code), .key_extended(key_extended), .key_release(key_release),
        .key_valid(key_valid), .key_ready(key_ready), .fifo_full(fifo_full),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        data_in    = b;
        data_valid = 1'b1;
        repeat (hold) tick();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel);
        exp_q.push_back({code, ext, rel});
    endtask

    task automatic drain(input int n);
        key_ready = 1'b1;
        repeat (n) tick();
        key_ready = 1'b0;
        chk("drained_empty", {31'd0, key_valid}, 32'd0);
    endtask

    // Monitor: every accepted head event must match the oldest expected event.
    always @(negedge clk) begin
        if (rst && key_valid && key_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got=%h/%b/%b exp=none", key_code, key_extended, key_release);
            end else begin
                automatic logic [9:0] e = exp_q.pop_front();
                if ({key_code, key_extended, key_release} !== e) begin
                    failures++;
                    $display("FAIL event got=%h/%b/%b exp=%h/%b/%b",
                             key_code, key_extended, key_release, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("reset_outputs", {18'd0, key_code, key_extended, key_release, key_valid, fifo_full, overflow}, 32'd0);
        rst = 1'b1;
        tick();

        // Held data_valid: one event, visible one cycle after the rise.
        data_in    = 8'h1C;
        data_valid = 1'b1;
        chk("valid_before_edge", {31'd0, key_valid}, 32'd0);
        tick();
        chk("valid_latency", {31'd0, key_valid}, 32'd1);
        chk("head_1c", {22'd0, key_code, key_extended, key_release}, {22'd0, 8'h1C, 2'b00});
        expect_ev(8'h1C, 1'b0, 1'b0);
        repeat (9) tick();
        data_valid = 1'b0;
        tick();
        drain(4);

        key_ready = 1'b1;
        expect_ev(8'h75, 1'b1, 1'b1);
        send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
        expect_ev(8'h1C, 1'b0, 1'b1);
        send_byte(8'hF0, 1); send_byte(8'h1C, 1);
        expect_ev(8'h6B, 1'b1, 1'b0);
        send_byte(8'hE0, 1); send_byte(8'h6B, 1);
        drain(3);

        send_byte(8'hAA, 1); send_byte(8'hFA, 1);
        repeat (2) tick();
        chk("ctrl_bytes_no_event", {31'd0, key_valid}, 32'd0);

        // Fill, overflow, then push and pop on the same edge while full.
        expect_ev(8'h15, 1'b0, 1'b0); send_byte(8'h15, 1);
        expect_ev(8'h1D, 1'b0, 1'b0); send_byte(8'h1D, 1);
        expect_ev(8'h24, 1'b0, 1'b0); send_byte(8'h24, 1);
        chk("not_full_at_3", {31'd0, fifo_full}, 32'd0);
        expect_ev(8'h2D, 1'b0, 1'b0); send_byte(8'h2D, 1);
        chk("full_at_4", {31'd0, fifo_full}, 32'd1);
        chk("no_overflow_at_4", {31'd0, overflow}, 32'd0);
        send_byte(8'h2C, 1);
        chk("overflow_at_5", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);

        expect_ev(8'h34, 1'b0, 1'b0);
        data_in    = 8'h34;
        data_valid = 1'b1;
        key_ready  = 1'b1;
        tick();
        key_ready  = 1'b0;
        data_valid = 1'b0;
        chk("full_after_push_pop", {31'd0, fifo_full}, 32'd1);
        chk("no_overflow_push_pop", {31'd0, overflow}, 32'd0);
        tick();
        drain(6);

        // Reset in the middle of an extended sequence.
        key_ready = 1'b1;
        send_byte(8'hE0, 1);
        rst = 1'b0;
        repeat (2) tick();
        chk("reset_mid_valid", {31'd0, key_valid}, 32'd0);
        rst = 1'b1;
        tick();
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C, 1);
        drain(3);

        key_ready = 1'b1;
        send_byte(8'hF0, 1);
        repeat (150) tick();
`ifdef KEY_TIMEOUT_EN
        expect_ev(8'h1C, 1'b0, 1'b0);
`else
        expect_ev(8'h1C, 1'b0, 1'b1);
`endif
        send_byte(8'h1C, 1);
        drain(3);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
